mux_scan_serializer: RTL and testbench

// - Sequencer that drives the 8:1 mux stage. It accepts an 8-bit word on a

---
 rtl/mux_scan_serializer_if.sv | 25 ++
 rtl/mux_scan_serializer.sv | 114 +++++++++++
 tb/tb_mux_scan_serializer.sv | 174 +++++++++++++++++
 3 files changed

// File: rtl/mux_scan_serializer_if.sv
// Bundle of the load handshake, mux drive/return and serial/self-check outputs
// for mux_scan_serializer. The sequencer sits on the master side.
interface mux_scan_serializer_if;
  logic       load_valid;
  logic [7:0] load_data;
  logic       load_ready;
  logic [7:0] mux_in;
  logic [2:0] mux_sel;
  logic       mux_out;
  logic       ser_bit;
  logic       ser_valid;
  logic       frame_done;
  logic [7:0] cap_word;
  logic       cap_match;

  modport master (
    input  load_valid, load_data, mux_out,
    output load_ready, mux_in, mux_sel, ser_bit, ser_valid, frame_done, cap_word, cap_match
  );

  modport slave (
    output load_valid, load_data, mux_out,
    input  load_ready, mux_in, mux_sel, ser_bit, ser_valid, frame_done, cap_word, cap_match
  );
endinterface

// File: rtl/mux_scan_serializer.sv
// Drives a loaded word onto an 8:1 mux, walks the select through all indices,
// serializes the sampled mux output and reassembles it for a loopback compare.
module mux_scan_serializer #(
  parameter int unsigned HOLD_CYCLES = 1,
  parameter bit          MSB_FIRST   = 1'b0
) (
  input  logic                  clk,
  input  logic                  rst,
  mux_scan_serializer_if.master bus
);

  localparam int unsigned CntW     = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [CntW-1:0] LastCnt  = CntW'(HOLD_CYCLES - 1);
  localparam logic [2:0]      FirstSel = MSB_FIRST ? 3'd7 : 3'd0;
  localparam logic [2:0]      LastSel  = MSB_FIRST ? 3'd0 : 3'd7;

  typedef enum logic [1:0] {StIdle, StSettle, StDone} state_e;

  state_e          state_q, state_d;
  logic [7:0]      mux_in_q, mux_in_d;
  logic [2:0]      mux_sel_q, mux_sel_d;
  logic            ser_bit_q, ser_bit_d;
  logic            ser_valid_q, ser_valid_d;
  logic            frame_done_q, frame_done_d;
  logic [7:0]      cap_word_q, cap_word_d;
  logic            cap_match_q, cap_match_d;
  logic [CntW-1:0] hold_cnt_q, hold_cnt_d;
  logic [7:0]      cap_ins;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StIdle;
      mux_in_q     <= '0;
      mux_sel_q    <= '0;
      ser_bit_q    <= 1'b0;
      ser_valid_q  <= 1'b0;
      frame_done_q <= 1'b0;
      cap_word_q   <= '0;
      cap_match_q  <= 1'b0;
      hold_cnt_q   <= '0;
    end else begin
      state_q      <= state_d;
      mux_in_q     <= mux_in_d;
      mux_sel_q    <= mux_sel_d;
      ser_bit_q    <= ser_bit_d;
      ser_valid_q  <= ser_valid_d;
      frame_done_q <= frame_done_d;
      cap_word_q   <= cap_word_d;
      cap_match_q  <= cap_match_d;
      hold_cnt_q   <= hold_cnt_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    mux_in_d     = mux_in_q;
    mux_sel_d    = mux_sel_q;
    ser_bit_d    = ser_bit_q;
    ser_valid_d  = 1'b0;
    frame_done_d = 1'b0;
    cap_word_d   = cap_word_q;
    cap_match_d  = cap_match_q;
    hold_cnt_d   = hold_cnt_q;
    // Captured word including the bit being sampled this edge.
    cap_ins           = cap_word_q;
    cap_ins[mux_sel_q] = bus.mux_out;

    unique case (state_q)
      StIdle: begin
        if (bus.load_valid) begin
          mux_in_d    = bus.load_data;
          mux_sel_d   = FirstSel;
          cap_word_d  = '0;
          cap_match_d = 1'b0;
          hold_cnt_d  = '0;
          state_d     = StSettle;
        end
      end
      StSettle: begin
        if (hold_cnt_q == LastCnt) begin
          ser_bit_d   = bus.mux_out;
          ser_valid_d = 1'b1;
          cap_word_d  = cap_ins;
          hold_cnt_d  = '0;
          if (mux_sel_q == LastSel) begin
            state_d      = StDone;
            frame_done_d = 1'b1;
            cap_match_d  = (cap_ins == mux_in_q);
          end else begin
            mux_sel_d = MSB_FIRST ? (mux_sel_q - 3'd1) : (mux_sel_q + 3'd1);
          end
        end else begin
          hold_cnt_d = hold_cnt_q + CntW'(1);
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  assign bus.load_ready = (state_q == StIdle);
  assign bus.mux_in     = mux_in_q;
  assign bus.mux_sel    = mux_sel_q;
  assign bus.ser_bit    = ser_bit_q;
  assign bus.ser_valid  = ser_valid_q;
  assign bus.frame_done = frame_done_q;
  assign bus.cap_word   = cap_word_q;
  assign bus.cap_match  = cap_match_q;

endmodule

// File: tb/tb_mux_scan_serializer.sv
// Directed bench for mux_scan_serializer: three parameterizations, a mux model,
// and a scoreboard of expected serial bits checked as they appear.
module tb_mux_scan_serializer;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mux_scan_serializer_if if0 ();
  mux_scan_serializer_if if1 ();
  mux_scan_serializer_if if2 ();

  mux_scan_serializer #(.HOLD_CYCLES(1), .MSB_FIRST(1'b0)) u_dut0 (.clk(clk), .rst(rst), .bus(if0));
  mux_scan_serializer #(.HOLD_CYCLES(1), .MSB_FIRST(1'b1)) u_dut1 (.clk(clk), .rst(rst), .bus(if1));
  mux_scan_serializer #(.HOLD_CYCLES(3), .MSB_FIRST(1'b0)) u_dut2 (.clk(clk), .rst(rst), .bus(if2));

  logic       stuck;
  logic       lv [3];
  logic [7:0] ld [3];

  assign if0.load_valid = lv[0];
  assign if1.load_valid = lv[1];
  assign if2.load_valid = lv[2];
  assign if0.load_data  = ld[0];
  assign if1.load_data  = ld[1];
  assign if2.load_data  = ld[2];
  assign if0.mux_out = stuck ? 1'b0 : if0.mux_in[if0.mux_sel];
  assign if1.mux_out = if1.mux_in[if1.mux_sel];
  assign if2.mux_out = if2.mux_in[if2.mux_sel];

  logic       rdy [3], sv [3], sb [3], fd [3], cm [3];
  logic [7:0] mi [3], cw [3];
  logic [2:0] ms [3];

  assign rdy[0] = if0.load_ready; assign rdy[1] = if1.load_ready; assign rdy[2] = if2.load_ready;
  assign sv[0]  = if0.ser_valid;  assign sv[1]  = if1.ser_valid;  assign sv[2]  = if2.ser_valid;
  assign sb[0]  = if0.ser_bit;    assign sb[1]  = if1.ser_bit;    assign sb[2]  = if2.ser_bit;
  assign fd[0]  = if0.frame_done; assign fd[1]  = if1.frame_done; assign fd[2]  = if2.frame_done;
  assign cm[0]  = if0.cap_match;  assign cm[1]  = if1.cap_match;  assign cm[2]  = if2.cap_match;
  assign mi[0]  = if0.mux_in;     assign mi[1]  = if1.mux_in;     assign mi[2]  = if2.mux_in;
  assign cw[0]  = if0.cap_word;   assign cw[1]  = if1.cap_word;   assign cw[2]  = if2.cap_word;
  assign ms[0]  = if0.mux_sel;    assign ms[1]  = if1.mux_sel;    assign ms[2]  = if2.mux_sel;

  int   n_assert = 0;
  int   n_fail   = 0;
  logic exp_q [$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset(input int k);
    chk($sformatf("rst_ready%0d", k), 32'(rdy[k]), 32'd1);
    chk($sformatf("rst_mux_in%0d", k), 32'(mi[k]), 32'd0);
    chk($sformatf("rst_mux_sel%0d", k), 32'(ms[k]), 32'd0);
    chk($sformatf("rst_ser%0d", k), {30'd0, sb[k], sv[k]}, 32'd0);
    chk($sformatf("rst_done%0d", k), 32'(fd[k]), 32'd0);
    chk($sformatf("rst_cap%0d", k), {23'd0, cm[k], cw[k]}, 32'd0);
  endtask

  // Called at a negedge with the DUT idle; returns at the first idle negedge afterwards.
  task automatic frame(input int k, input logic [7:0] data, input logic [7:0] next_data,
                       input bit keep);
    int         h, c, pulses, step, idx;
    bit         msb, seen_done;
    logic [7:0] exp_cap;
    logic       b, e;
    h = (k == 2) ? 3 : 1;
    msb = (k == 1);
    lv[k] = 1'b1;
    ld[k] = data;
    chk("ready_before_accept", 32'(rdy[k]), 32'd1);
    exp_cap = '0;
    for (int i = 0; i < 8; i++) begin
      idx = msb ? 7 - i : i;
      b = (stuck && k == 0) ? 1'b0 : data[idx];
      exp_q.push_back(b);
      exp_cap[idx] = b;
    end
    @(posedge clk);
    @(negedge clk);
    if (keep) ld[k] = next_data;
    else lv[k] = 1'b0;
    c = 1;
    pulses = 0;
    seen_done = 1'b0;
    while (c < 60 && !rdy[k]) begin
      if (c <= 8 * h) begin
        step = (c - 1) / h;
        chk("mux_sel", 32'(ms[k]), msb ? 32'(7 - step) : 32'(step));
      end
      chk("mux_in", 32'(mi[k]), 32'(data));
      chk("ser_valid", 32'(sv[k]), (c >= 2 && (c - 1) % h == 0) ? 32'd1 : 32'd0);
      chk("frame_done", 32'(fd[k]), (c == 8 * h + 1) ? 32'd1 : 32'd0);
      if (sv[k]) begin
        pulses++;
        e = (exp_q.size() > 0) ? exp_q.pop_front() : 1'bx;
        chk("ser_bit", 32'(sb[k]), 32'(e));
      end
      if (fd[k]) begin
        seen_done = 1'b1;
        chk("pulses_at_done", 32'(pulses), 32'd8);
        chk("cap_word", 32'(cw[k]), 32'(exp_cap));
        chk("cap_match", 32'(cm[k]), (exp_cap == data) ? 32'd1 : 32'd0);
      end
      @(negedge clk);
      c++;
    end
    chk("frame_len", 32'(c - 1), 32'(8 * h + 1));
    chk("done_seen", 32'(seen_done), 32'd1);
    chk("sb_empty", 32'(exp_q.size()), 32'd0);
    chk("idle_cap_hold", {23'd0, cm[k], cw[k]},
        {23'd0, (exp_cap == data) ? 1'b1 : 1'b0, exp_cap});
    exp_q.delete();
  endtask

  initial begin
    int pulses;
    stuck = 1'b0;
    for (int k = 0; k < 3; k++) begin
      lv[k] = 1'b0;
      ld[k] = '0;
    end
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int k = 0; k < 3; k++) chk_reset(k);
    rst = 1'b0;
    @(negedge clk);

    frame(0, 8'hAA, 8'h00, 1'b0);
    frame(1, 8'hCC, 8'h00, 1'b0);
    frame(2, 8'h0F, 8'h00, 1'b0);

    stuck = 1'b1;
    frame(0, 8'hAA, 8'h00, 1'b0);
    stuck = 1'b0;

    // Offer held through the frame must wait for idle, then go in with one idle cycle.
    frame(0, 8'hAA, 8'h55, 1'b1);
    frame(0, 8'h55, 8'h00, 1'b0);

    // Abort after the 4th serial bit.
    lv[0] = 1'b1;
    ld[0] = 8'hAA;
    @(posedge clk);
    @(negedge clk);
    lv[0] = 1'b0;
    pulses = 0;
    for (int c = 0; c < 30 && pulses < 4; c++) begin
      if (sv[0]) pulses++;
      if (pulses < 4) @(negedge clk);
    end
    chk("abort_reach4", 32'(pulses), 32'd4);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk_reset(0);
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      chk("abort_no_done", 32'(fd[0]), 32'd0);
      chk("abort_ready", 32'(rdy[0]), 32'd1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
